// File: rtl/pc_fetch_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// Imported by the interface, the next-PC selector and the sequencer top.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } state_e;

  localparam int unsigned INSTR_BYTES = 4;

  // Low address bits that must be zero in a word-aligned fetch address.
  localparam int unsigned ALIGN_MASK = INSTR_BYTES - 1;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory request port plus the IF/ID delivery signals.
// valid/ready: a request is issued while imem_req=1 and completes on the cycle imem_ready=1; imem_addr holds until then.
interface pc_fetch_sequencer_if #(
  parameter int SIZE = 32
);
  logic            imem_req;
  logic [SIZE-1:0] imem_addr;
  logic            imem_ready;
  logic            fetch_valid;
  logic [SIZE-1:0] fetch_pc;
  logic [SIZE-1:0] fetch_pc_plus4;

  modport master (
    output imem_req, imem_addr, fetch_valid, fetch_pc, fetch_pc_plus4,
    input  imem_ready
  );

  modport slave (
    input  imem_req, imem_addr, fetch_valid, fetch_pc, fetch_pc_plus4,
    output imem_ready
  );
endinterface

// File: rtl/pc_fetch_sequencer_next_pc_sel.sv
// Combinational redirect arbitration (exception > jump > branch) and
// sequential next-address computation.
module next_pc_sel
  import pc_seq_pkg::*;
#(
  parameter int              SIZE       = 32,
  parameter logic [SIZE-1:0] EXC_VECTOR = SIZE'(DEF_EXC_VECTOR)
) (
  input  logic [SIZE-1:0] pc,
  input  logic            exception,
  input  logic            jump,
  input  logic [SIZE-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [SIZE-1:0] branch_target,
  output logic            redirect,
  output logic [SIZE-1:0] target,
  output logic [SIZE-1:0] pc_plus4
);
  logic [SIZE-1:0] raw_target;

  always_comb begin
    raw_target = '0;
    if (exception)         raw_target = EXC_VECTOR;
    else if (jump)         raw_target = jump_target;
    else if (branch_taken) raw_target = branch_target;
  end

  assign redirect = exception | jump | branch_taken;
  assign target   = raw_target & ~SIZE'(ALIGN_MASK);
  // Natural modulo-2^SIZE wrap of the adder gives 0xFFFFFFFC -> 0x0.
  assign pc_plus4 = pc + SIZE'(INSTR_BYTES);
endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage PC owner: issues instruction-memory requests, applies redirects,
// honours stall/halt and squashes responses made stale by a redirect.
module pc_fetch_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              SIZE         = 32,
  parameter logic [SIZE-1:0] RESET_VECTOR = SIZE'(DEF_RESET_VECTOR),
  parameter logic [SIZE-1:0] EXC_VECTOR   = SIZE'(DEF_EXC_VECTOR)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  halt,
  input  logic                  branch_taken,
  input  logic [SIZE-1:0]       branch_target,
  input  logic                  jump,
  input  logic [SIZE-1:0]       jump_target,
  input  logic                  exception,
  pc_fetch_sequencer_if.master  bus,
  output logic                  halted,
  output state_e                state_dbg
);
  state_e          state, state_nx;
  logic [SIZE-1:0] pc, pc_nx;
  logic [SIZE-1:0] req_addr, req_addr_nx;
  logic            squash, squash_nx;

  logic            redirect;
  logic [SIZE-1:0] target, pc_plus4;

  logic            req_c, fv_c, halted_c;
  logic [SIZE-1:0] addr_c, fpc_c;

  next_pc_sel #(.SIZE(SIZE), .EXC_VECTOR(EXC_VECTOR)) u_sel (
    .pc            (pc),
    .exception     (exception),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .redirect      (redirect),
    .target        (target),
    .pc_plus4      (pc_plus4)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= BOOT;
      pc       <= RESET_VECTOR;
      req_addr <= '0;
      squash   <= 1'b0;
    end else begin
      state    <= state_nx;
      pc       <= pc_nx;
      req_addr <= req_addr_nx;
      squash   <= squash_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    req_addr_nx = req_addr;
    squash_nx   = squash;
    req_c       = 1'b0;
    addr_c      = '0;
    fv_c        = 1'b0;
    fpc_c       = '0;
    halted_c    = 1'b0;
    case (state)
      BOOT: state_nx = FETCH;
      FETCH: begin
        if (redirect) begin
          pc_nx = target;
        end else if (halt) begin
          state_nx = HALTED;
        end else if (!stall) begin
          req_c       = 1'b1;
          addr_c      = pc;
          req_addr_nx = pc;
          pc_nx       = pc_plus4;
          if (bus.imem_ready) begin
            fv_c  = 1'b1;
            fpc_c = pc;
          end else begin
            state_nx = WAIT;
          end
        end
      end
      WAIT: begin
        req_c  = 1'b1;
        addr_c = req_addr;
        if (redirect) pc_nx = target;
        // A redirect in the response cycle also kills the instruction.
        if (bus.imem_ready) begin
          fv_c      = !squash && !redirect;
          fpc_c     = req_addr;
          squash_nx = 1'b0;
          state_nx  = FETCH;
        end else if (redirect) begin
          squash_nx = 1'b1;
        end
      end
      HALTED: begin
        halted_c = 1'b1;
        if (exception) begin
          pc_nx    = EXC_VECTOR;
          state_nx = FETCH;
        end
      end
      default: state_nx = BOOT;
    endcase
  end

  // Outputs are forced idle for the whole cycle in which rst is sampled.
  assign bus.imem_req       = req_c & ~rst;
  assign bus.imem_addr      = rst ? '0 : addr_c;
  assign bus.fetch_valid    = fv_c & ~rst;
  assign bus.fetch_pc       = rst ? '0 : fpc_c;
  assign bus.fetch_pc_plus4 = bus.fetch_pc + SIZE'(INSTR_BYTES);
  assign halted             = halted_c & ~rst;
  assign state_dbg          = state;
endmodule
